mem_dump_reader: RTL and testbench
==================================

// Module: mem_dump_reader
// PURPOSE
//  Debug-unit side of the data-memory dump port: walks a range of the byte-addressed data
//  memory through its dedicated debug read port (combinational, big-endian 32-bit word at
//  addr..addr+3), then streams each word out MSB byte first over a valid/ready byte interface
//  toward the UART TX path. Sits inside the debug unit, between data memory and UART transmitter.
// PARAMETERS
//  NB_WIDTH  32  memory word width; multiple of 8; bytes per word NB_WB = NB_WIDTH/8
//  NB_ADDR   9   byte-address width of data memory (512 bytes)
//  NB_CNT    8   width of word-count request
// PORTS
//  i_clk           in   1         clock, all logic on rising edge
//  i_reset         in   1         synchronous reset, active-low
//  i_start         in   1         start request, sampled only in IDLE
//  i_base_addr     in   NB_ADDR   first byte address of dump (word-aligned by caller)
//  i_word_count    in   NB_CNT    number of words to dump; 0 = nothing
//  o_dunit_addr    out  NB_ADDR   registered address to memory debug read port
//  i_dunit_data    in   NB_WIDTH  memory debug read data (async, valid same cycle as addr)
//  o_tx_data       out  8         byte to transmitter
//  o_tx_valid      out  1         byte valid
//  i_tx_ready      in   1         transmitter accepts byte when valid&ready
//  o_busy          out  1         high in any state except IDLE
//  o_done          out  1         one-cycle pulse at end of dump
// BEHAVIOUR
//  Reset (i_reset==0 at edge): state IDLE; o_dunit_addr=0, o_tx_data=0, o_tx_valid=0,
//   o_busy=0, o_done=0, word/byte/count registers 0. Reset mid-dump aborts; no done pulse.
//  FSM states: IDLE, FETCH, SEND, DONE.
//  IDLE: on i_start: latch addr<=i_base_addr, left<=i_word_count; go FETCH if count!=0,
//   else DONE. i_start in any other state ignored (no queueing).
//  FETCH (1 cycle): o_dunit_addr holds addr; latch word<=i_dunit_data, byte_idx<=0; go SEND.
//  SEND: o_tx_valid=1, o_tx_data=word[NB_WIDTH-1-8*byte_idx -: 8] (MSB byte first).
//   o_tx_data and o_tx_valid held stable until valid&ready; no valid drop while waiting.
//   On accept: byte_idx<NB_WB-1 -> byte_idx+1, stay SEND (next byte visible next cycle);
//   byte_idx==NB_WB-1 -> left-1; if left becomes 0 -> DONE, else addr<=addr+NB_WB, FETCH.
//  DONE: o_done=1 for exactly one cycle, o_tx_valid=0; -> IDLE.
//  Latency: i_start sampled at edge N -> o_dunit_addr=base after N; first o_tx_valid after N+1.
//   Each word costs 1 FETCH cycle + NB_WB accepts; with ready tied high, 5 cycles/word.
//  Address arithmetic modulo 2**NB_ADDR: addr+4 past top wraps to low addresses silently.
//  i_tx_ready ignored outside SEND. Word captured once in FETCH; later memory writes to
//   that address do not change bytes already latched.
// STRUCTURE
//  Shared debug-unit package: state encoding localparams (IDLE/FETCH/SEND/DONE), NB_BYTE=8,
//   default NB_ADDR/NB_WIDTH so memory and debug unit agree.
//  One sub-module natural: word_byte_serializer (load word, emit NB_WB bytes MSB-first
//   with valid/ready, flag last-byte accept); top holds FSM, address and count.
// TESTING
//  Reset: drive i_reset=0 two cycles mid-SEND -> next cycle o_tx_valid=0, o_busy=0, no o_done.
//  Single word: base=0x010, count=1, mem[0x10..0x13]=DE AD BE EF, ready=1 -> bytes DE,AD,BE,EF
//   on 4 consecutive cycles, o_done pulse 1 cycle after EF accepted, o_busy low after.
//  Backpressure: same word, ready toggled 1-0-0-1-0-1-1 -> each byte held stable until
//   accepted, order DE,AD,BE,EF, no duplicates or drops.
//  Count 0: start with count=0 -> o_tx_valid never asserted, o_done pulses next cycle after start.
//  Wrap: base=0x1FC, count=2, mem[0x1FC..]=11 22 33 44, mem[0x000..]=55 66 77 88 ->
//   o_dunit_addr 0x1FC then 0x000; bytes 11..88 in order.
//  Start while busy: second i_start during SEND -> ignored; only original dump emitted.

Source files
------------

// File: rtl/mem_dump_reader_pkg.sv
// Shared debug-unit definitions. The memory and the dump reader both pick up
// their default widths here, so the two sides cannot disagree.
package mem_dump_reader_pkg;

    localparam int NB_BYTE      = 8;
    localparam int NB_WIDTH_DEF = 32;
    localparam int NB_ADDR_DEF  = 9;
    localparam int NB_CNT_DEF   = 8;

    // Dump FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int bytes_per_word(input int nb_width);
        return nb_width / NB_BYTE;
    endfunction

endpackage

// File: rtl/mem_dump_reader_serializer.sv
// Holds one memory word and hands it out a byte at a time, MSB byte first,
// over a valid/ready interface. The word is shifted left on each accepted
// byte, so the byte on offer is always the top byte of the register.
module mem_dump_reader_serializer
    import mem_dump_reader_pkg::*;
#(
    parameter int NB_WIDTH = NB_WIDTH_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                load,
    input  logic [NB_WIDTH-1:0] word_in,
    input  logic                tx_ready,
    output logic [NB_BYTE-1:0]  tx_data,
    output logic                tx_valid,
    output logic                last_accept
);

    localparam int NB_WB  = bytes_per_word(NB_WIDTH);
    localparam int NB_IDX = (NB_WB > 1) ? $clog2(NB_WB) : 1;
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NB_WB - 1);

    logic [NB_WIDTH-1:0] word_q;
    logic [NB_IDX-1:0]   byte_idx;
    logic                valid_q;
    logic                accept;

    assign accept      = valid_q & tx_ready;
    assign last_accept = accept & (byte_idx == LAST_IDX);
    assign tx_data     = word_q[NB_WIDTH-1 -: NB_BYTE];
    assign tx_valid    = valid_q;

    // Capture the word on load, then advance one byte per accepted transfer
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            word_q   <= '0;
            byte_idx <= '0;
            valid_q  <= 1'b0;
        end else if (load) begin
            word_q   <= word_in;
            byte_idx <= '0;
            valid_q  <= 1'b1;
        end else if (accept) begin
            if (byte_idx == LAST_IDX) begin
                valid_q <= 1'b0;
            end else begin
                word_q   <= word_q << NB_BYTE;
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// Debug-unit memory dump: walks a word range of data memory through the
// debug read port and streams every word out MSB byte first toward the UART.
//
//  state | meaning
//  IDLE  | waiting for i_start
//  FETCH | o_dunit_addr is on the read port, word captured at end of cycle
//  SEND  | bytes of the captured word offered to the transmitter
//  DONE  | one-cycle o_done pulse, then back to IDLE
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int NB_WIDTH = NB_WIDTH_DEF,
    parameter int NB_ADDR  = NB_ADDR_DEF,
    parameter int NB_CNT   = NB_CNT_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_ADDR-1:0]  i_base_addr,
    input  logic [NB_CNT-1:0]   i_word_count,
    output logic [NB_ADDR-1:0]  o_dunit_addr,
    input  logic [NB_WIDTH-1:0] i_dunit_data,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_busy,
    output logic                o_done
);

    localparam int NB_WB = bytes_per_word(NB_WIDTH);

    logic [1:0]         state;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_CNT-1:0]  left_q;
    logic               last_accept;

    assign o_dunit_addr = addr_q;
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = (state == ST_DONE);

    mem_dump_reader_serializer #(
        .NB_WIDTH (NB_WIDTH)
    ) u_serializer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .load        (state == ST_FETCH),
        .word_in     (i_dunit_data),
        .tx_ready    (i_tx_ready),
        .tx_data     (o_tx_data),
        .tx_valid    (o_tx_valid),
        .last_accept (last_accept)
    );

    // Sequencing: address walk (wraps modulo memory size) and words-left down-counter
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            left_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        addr_q <= i_base_addr;
                        left_q <= i_word_count;
                        state  <= (i_word_count != '0) ? ST_FETCH : ST_DONE;
                    end
                end
                ST_FETCH: state <= ST_SEND;
                ST_SEND: begin
                    if (last_accept) begin
                        left_q <= left_q - NB_CNT'(1);
                        if (left_q == NB_CNT'(1)) begin
                            state <= ST_DONE;
                        end else begin
                            addr_q <= addr_q + NB_ADDR'(NB_WB);
                            state  <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: byte-level memory model, a queue-based reference
// of the expected byte stream checked every cycle, plus literal expectations.
module tb_mem_dump_reader;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [8:0]  i_base_addr = '0;
    logic [7:0]  i_word_count = '0;
    logic [8:0]  o_dunit_addr;
    logic [31:0] i_dunit_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_busy;
    logic        o_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:511];

    always #5 i_clk = ~i_clk;

    assign i_dunit_data = {mem[o_dunit_addr], mem[o_dunit_addr + 9'd1],
                           mem[o_dunit_addr + 9'd2], mem[o_dunit_addr + 9'd3]};

    mem_dump_reader dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_word_count (i_word_count),
        .o_dunit_addr (o_dunit_addr),
        .i_dunit_data (i_dunit_data),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic       m_started = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_done = 1'b0;
    logic       m_fetch = 1'b0;
    logic [8:0] m_addr = '0;
    int         m_sent = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [8:0] fetch_log[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge i_clk) begin
        if (m_started) begin
            check("busy", 32'(o_busy), 32'(m_busy));
            check("done", 32'(o_done), 32'(m_done));
            check("valid", 32'(o_tx_valid), 32'(m_valid));
            if (m_valid) check("data", 32'(o_tx_data), 32'(exp_q[0]));
            if (m_fetch) begin
                check("fetch_addr", 32'(o_dunit_addr), 32'(m_addr));
                fetch_log.push_back(o_dunit_addr);
            end
            if (prev_hold) begin
                check("hold_valid", 32'(o_tx_valid), 32'd1);
                check("hold_data", 32'(o_tx_data), 32'(prev_data));
            end
            if (o_tx_valid && i_tx_ready && i_reset) rx_q.push_back(o_tx_data);
        end
        prev_hold = i_reset && (o_tx_valid === 1'b1) && !i_tx_ready;
        prev_data = o_tx_data;

        // what the coming rising edge must produce
        if (!i_reset) begin
            m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_fetch = 1'b0;
            exp_q.delete();
            m_started = 1'b1;
        end else if (!m_started) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (i_start) begin
                m_busy = 1'b1;
                m_addr = i_base_addr;
                m_sent = 0;
                exp_q.delete();
                for (int w = 0; w < int'(i_word_count); w++)
                    for (int b = 0; b < 4; b++)
                        exp_q.push_back(mem[9'(i_base_addr + 9'(4 * w + b))]);
                if (i_word_count == 8'd0) m_done = 1'b1;
                else m_fetch = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_fetch) begin
            m_fetch = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid && i_tx_ready) begin
            void'(exp_q.pop_front());
            m_sent++;
            if (exp_q.size() == 0) begin
                m_valid = 1'b0;
                m_done  = 1'b1;
            end else if (m_sent % 4 == 0) begin
                m_valid = 1'b0;
                m_fetch = 1'b1;
                m_addr  = m_addr + 9'd4;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_dump(input logic [8:0] base, input logic [7:0] cnt);
        i_start = 1'b1;
        i_base_addr = base;
        i_word_count = cnt;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (o_done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: no done pulse within %0d cycles", limit);
        end
    endtask

    task automatic check_rx(input string name, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input int base);
        check({name, "_len_min"}, 32'(rx_q.size() >= base + 4), 32'd1);
        if (rx_q.size() >= base + 4) begin
            check({name, "_b0"}, 32'(rx_q[base]),     32'(e0));
            check({name, "_b1"}, 32'(rx_q[base + 1]), 32'(e1));
            check({name, "_b2"}, 32'(rx_q[base + 2]), 32'(e2));
            check({name, "_b3"}, 32'(rx_q[base + 3]), 32'(e3));
        end
    endtask

    initial begin
        logic [7:0] single_exp [4];
        logic       bp_ready [7];
        single_exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        bp_ready   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 11);
        {mem[9'h010], mem[9'h011], mem[9'h012], mem[9'h013]} = 32'hDEADBEEF;
        {mem[9'h1FC], mem[9'h1FD], mem[9'h1FE], mem[9'h1FF]} = 32'h11223344;
        {mem[9'h000], mem[9'h001], mem[9'h002], mem[9'h003]} = 32'h55667788;

        // reset values
        i_reset = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_valid", 32'(o_tx_valid), 32'd0);
        check("rst_data", 32'(o_tx_data), 32'd0);
        check("rst_addr", 32'(o_dunit_addr), 32'd0);
        i_reset = 1'b1;
        tick();

        // single word, ready high: DE AD BE EF on consecutive cycles
        rx_q.delete();
        i_tx_ready = 1'b1;
        start_dump(9'h010, 8'd1);
        check("sw_addr", 32'(o_dunit_addr), 32'h010);
        check("sw_fetch_valid", 32'(o_tx_valid), 32'd0);
        check("sw_busy", 32'(o_busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("sw_valid", 32'(o_tx_valid), 32'd1);
            check("sw_byte", 32'(o_tx_data), 32'(single_exp[k]));
        end
        tick();
        check("sw_done", 32'(o_done), 32'd1);
        check("sw_done_valid", 32'(o_tx_valid), 32'd0);
        tick();
        check("sw_done_end", 32'(o_done), 32'd0);
        check("sw_idle", 32'(o_busy), 32'd0);
        check("sw_rx_len", 32'(rx_q.size()), 32'd4);
        check_rx("sw_rx", 8'hDE, 8'hAD, 8'hBE, 8'hEF, 0);

        // backpressure, plus a memory write after capture that must not leak
        rx_q.delete();
        start_dump(9'h010, 8'd1);
        tick();
        mem[9'h011] = 8'h00;
        for (int k = 0; k < 7; k++) begin
            i_tx_ready = bp_ready[k];
            tick();
        end
        check("bp_done", 32'(o_done), 32'd1);
        mem[9'h011] = 8'hAD;
        i_tx_ready = 1'b1;
        tick();
        check("bp_rx_len", 32'(rx_q.size()), 32'd4);
        check_rx("bp_rx", 8'hDE, 8'hAD, 8'hBE, 8'hEF, 0);

        // count 0: done pulse next cycle, no valid
        start_dump(9'h020, 8'd0);
        check("c0_done", 32'(o_done), 32'd1);
        check("c0_valid", 32'(o_tx_valid), 32'd0);
        tick();
        check("c0_done_end", 32'(o_done), 32'd0);
        check("c0_idle", 32'(o_busy), 32'd0);

        // address wrap across the top of memory
        rx_q.delete();
        fetch_log.delete();
        start_dump(9'h1FC, 8'd2);
        wait_done(40);
        tick();
        check("wr_fetch_cnt", 32'(fetch_log.size()), 32'd2);
        if (fetch_log.size() == 2) begin
            check("wr_addr0", 32'(fetch_log[0]), 32'h1FC);
            check("wr_addr1", 32'(fetch_log[1]), 32'h000);
        end
        check("wr_rx_len", 32'(rx_q.size()), 32'd8);
        check_rx("wr_rx_w0", 8'h11, 8'h22, 8'h33, 8'h44, 0);
        check_rx("wr_rx_w1", 8'h55, 8'h66, 8'h77, 8'h88, 4);

        // multi-word with periodic backpressure (model-checked)
        rx_q.delete();
        start_dump(9'h040, 8'd3);
        for (int n = 0; n < 60 && o_done !== 1'b1; n++) begin
            i_tx_ready = (n % 3 != 1);
            tick();
        end
        check("mw_done", 32'(o_done), 32'd1);
        i_tx_ready = 1'b1;
        tick();
        check("mw_rx_len", 32'(rx_q.size()), 32'd12);

        // start while busy is ignored
        rx_q.delete();
        start_dump(9'h010, 8'd1);
        tick();
        start_dump(9'h1FC, 8'd2);
        wait_done(40);
        tick();
        check("sb_rx_len", 32'(rx_q.size()), 32'd4);
        check_rx("sb_rx", 8'hDE, 8'hAD, 8'hBE, 8'hEF, 0);
        tick(); tick();
        check("sb_idle", 32'(o_busy), 32'd0);

        // reset mid-SEND aborts with no done pulse
        start_dump(9'h010, 8'd2);
        tick();
        i_tx_ready = 1'b0;
        check("mr_in_send", 32'(o_tx_valid), 32'd1);
        i_reset = 1'b0;
        tick(); tick();
        check("mr_valid", 32'(o_tx_valid), 32'd0);
        check("mr_busy", 32'(o_busy), 32'd0);
        check("mr_done", 32'(o_done), 32'd0);
        check("mr_data", 32'(o_tx_data), 32'd0);
        i_reset = 1'b1;
        i_tx_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mr_no_done", 32'(o_done), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
